// File: rtl/led_disp_pkg.sv
// Shared definitions for the LED value scanner: FSM state encoding and
// default build-time constants.
package led_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } disp_state_e;

  localparam int DEF_DIGIT_W      = 4;
  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_DWELL_CYCLES = 6_000_000;
  localparam int DEF_GAP_CYCLES   = 3_000_000;
  localparam int DEF_PWM_W        = 8;

endpackage

// File: rtl/pwm.sv
// Free-running PWM. The duty is latched once per period so a mid-period
// change never produces a runt pulse.
module pwm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_out
);

  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] duty_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      duty_l  <= '0;
      pwm_out <= 1'b0;
    end else begin
      phase <= phase + 1'b1;
      if (phase == '1) begin
        duty_l <= duty;
      end
      pwm_out <= (phase < duty_l);
    end
  end

endmodule

// File: rtl/led_value_scanner.sv
// Shows a multi-digit value one digit at a time on a small LED bank, with a
// PWM brightness cue for the digit position and a one-entry input buffer.
//
//   state | meaning
//   IDLE  | blank, waiting for a pending value
//   SHOW  | one digit on the LEDs for the dwell time, then the next digit
//   GAP   | blank between frames; at the end load pending, repeat, or idle
module led_value_scanner
  import led_disp_pkg::*;
#(
  parameter int DIGIT_W      = DEF_DIGIT_W,
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int PWM_W        = DEF_PWM_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] in_value,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          repeat_en,
  output logic [DIGIT_W-1:0]            leds,
  output logic                          led_pos,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int VAL_W   = DIGIT_W * NUM_DIGITS;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int DG_MAX  = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2((DG_MAX > 2) ? DG_MAX : 2);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  localparam logic [CNT_W-1:0] DWELL_TC = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  disp_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [VAL_W-1:0] disp_reg, disp_n;
  logic [VAL_W-1:0] pend_reg;
  logic             pending_full;
  logic             pend_take;
  logic             accept;
  logic             last_tick;
  logic             frame_end;
  logic [DIGIT_W-1:0] cur_digit;
  logic [PWM_W-1:0]   duty;

  // Brightness halves twice per position; the last digit is always dark.
  function automatic logic [PWM_W-1:0] pos_duty(input logic [IDX_W-1:0] k);
    logic [PWM_W:0] full;
    logic [PWM_W:0] v;
    full = {1'b1, {PWM_W{1'b0}}};
    v    = full >> {k, 1'b0};
    if (k == LAST_IDX) begin
      return '0;
    end
    if (v[PWM_W]) begin
      return '1;
    end
    return v[PWM_W-1:0];
  endfunction

  assign in_ready = !pending_full;
  assign accept   = in_valid && !pending_full;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_full <= 1'b0;
      pend_reg     <= '0;
    end else if (accept) begin
      pending_full <= 1'b1;
      pend_reg     <= in_value;
    end else if (pend_take) begin
      pending_full <= 1'b0;
    end
  end

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = disp_reg[VAL_W-1-i*DIGIT_W -: DIGIT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      disp_reg <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      disp_reg <= disp_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    disp_n    = disp_reg;
    pend_take = 1'b0;
    last_tick = 1'b0;
    frame_end = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (pending_full) begin
          disp_n    = pend_reg;
          pend_take = 1'b1;
          state_n   = SHOW;
        end
      end
      SHOW: begin
        if (cnt == DWELL_TC) begin
          cnt_n = '0;
          if (idx != LAST_IDX) begin
            idx_n = idx + 1'b1;
          end else begin
            last_tick = 1'b1;
            if (HAS_GAP) begin
              state_n = GAP;
            end else begin
              frame_end = 1'b1;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_TC) begin
          cnt_n     = '0;
          frame_end = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase

    // A newer value always wins over replaying the current one.
    if (frame_end) begin
      idx_n = '0;
      if (pending_full) begin
        disp_n    = pend_reg;
        pend_take = 1'b1;
        state_n   = SHOW;
      end else if (repeat_en) begin
        state_n = SHOW;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds       <= '0;
      digit_idx  <= '0;
      duty       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_tick;
      if (state == SHOW) begin
        leds      <= cur_digit;
        digit_idx <= idx;
        duty      <= pos_duty(idx);
      end else begin
        leds      <= '0;
        digit_idx <= '0;
        duty      <= '0;
      end
    end
  end

  pwm #(
    .WIDTH(PWM_W)
  ) u_pwm (
    .clk    (clk),
    .rst    (rst),
    .duty   (duty),
    .pwm_out(led_pos)
  );

endmodule

// File: tb/tb_led_value_scanner.sv
// Self-checking bench: per-cycle expected traces are queued when stimulus is
// driven and popped against the DUT outputs on each falling edge.
module tb_led_value_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         duty_q[$];

  // main instance: dwell 4, gap 2
  logic        m_rst, m_in_valid, m_in_ready, m_repeat_en, m_led_pos, m_busy, m_frame_done;
  logic [15:0] m_in_value;
  logic [3:0]  m_leds;
  logic [1:0]  m_digit_idx;
  // pwm instance: dwell 1024, gap 2
  logic        p_rst, p_in_valid, p_in_ready, p_repeat_en, p_led_pos, p_busy, p_frame_done;
  logic [15:0] p_in_value;
  logic [3:0]  p_leds;
  logic [1:0]  p_digit_idx;
  // zero-gap instance: dwell 4, gap 0
  logic        g_rst, g_in_valid, g_in_ready, g_repeat_en, g_led_pos, g_busy, g_frame_done;
  logic [15:0] g_in_value;
  logic [3:0]  g_leds;
  logic [1:0]  g_digit_idx;

  led_value_scanner #(
    .DIGIT_W(4), .NUM_DIGITS(4), .DWELL_CYCLES(4), .GAP_CYCLES(2), .PWM_W(8)
  ) u_main (
    .clk(clk), .rst(m_rst), .in_value(m_in_value), .in_valid(m_in_valid),
    .in_ready(m_in_ready), .repeat_en(m_repeat_en), .leds(m_leds), .led_pos(m_led_pos),
    .digit_idx(m_digit_idx), .busy(m_busy), .frame_done(m_frame_done)
  );

  led_value_scanner #(
    .DIGIT_W(4), .NUM_DIGITS(4), .DWELL_CYCLES(1024), .GAP_CYCLES(2), .PWM_W(8)
  ) u_pwmchk (
    .clk(clk), .rst(p_rst), .in_value(p_in_value), .in_valid(p_in_valid),
    .in_ready(p_in_ready), .repeat_en(p_repeat_en), .leds(p_leds), .led_pos(p_led_pos),
    .digit_idx(p_digit_idx), .busy(p_busy), .frame_done(p_frame_done)
  );

  led_value_scanner #(
    .DIGIT_W(4), .NUM_DIGITS(4), .DWELL_CYCLES(4), .GAP_CYCLES(0), .PWM_W(8)
  ) u_gap0 (
    .clk(clk), .rst(g_rst), .in_value(g_in_value), .in_valid(g_in_valid),
    .in_ready(g_in_ready), .repeat_en(g_repeat_en), .leds(g_leds), .led_pos(g_led_pos),
    .digit_idx(g_digit_idx), .busy(g_busy), .frame_done(g_frame_done)
  );

  // Record layout: {leds[3:0], digit_idx[1:0], frame_done, busy}
  task automatic push_lead();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
  endtask

  task automatic push_frame(input logic [15:0] v, input int n, input logic last_busy);
    for (int i = 0; i < n; i++) begin
      int         k;
      logic [3:0] d;
      k = i / 4;
      d = v[15 - 4*k -: 4];
      exp_q.push_back({d, 2'(k), (i == 15), (i == 15) ? last_busy : 1'b1});
    end
  endtask

  task automatic push_gap(input logic second_busy);
    exp_q.push_back(8'h01);
    exp_q.push_back({7'h00, second_busy});
  endtask

  task automatic push_idle(input int n);
    repeat (n) exp_q.push_back(8'h00);
  endtask

  task automatic test_reset();
    m_rst = 1'b1; p_rst = 1'b1; g_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_leds, m_digit_idx, m_frame_done, m_busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 00", {m_leds, m_digit_idx, m_frame_done, m_busy});
    end
    checks++;
    if (m_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", m_in_ready);
    end
    checks++;
    if (m_led_pos !== 1'b0) begin
      errors++;
      $display("FAIL reset_led_pos got %b exp 0", m_led_pos);
    end
    checks++;
    if ({g_busy, g_leds, p_busy, p_leds} !== 10'h000) begin
      errors++;
      $display("FAIL reset_other_inst got %h exp 000", {g_busy, g_leds, p_busy, p_leds});
    end
    m_rst = 1'b0; p_rst = 1'b0; g_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_busy, m_in_ready, m_leds} !== 6'b010000) begin
      errors++;
      $display("FAIL idle_after_reset got %b exp 010000", {m_busy, m_in_ready, m_leds});
    end
  endtask

  task automatic test_single_frame();
    int         n;
    int         fd_cnt = 0;
    logic [7:0] e;
    exp_q.delete();
    @(negedge clk);
    m_in_value = 16'hA5C3; m_in_valid = 1'b1; m_repeat_en = 1'b0;
    push_lead(); push_frame(16'hA5C3, 16, 1'b1); push_gap(1'b0); push_idle(3);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({m_leds, m_digit_idx, m_frame_done, m_busy} !== e) begin
        errors++;
        $display("FAIL single_trace c=%0d got %h exp %h", c, {m_leds, m_digit_idx, m_frame_done, m_busy}, e);
      end
      fd_cnt += int'(m_frame_done);
      if (c == 1) begin
        checks++;
        if (m_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL single_ready_after_accept got %b exp 0", m_in_ready);
        end
        m_in_valid = 1'b0;
      end
    end
    checks++;
    if (fd_cnt != 1) begin
      errors++;
      $display("FAIL single_frame_done_count got %0d exp 1", fd_cnt);
    end
  endtask

  task automatic test_repeat();
    int         n;
    int         fd_cnt = 0;
    logic [7:0] e;
    exp_q.delete();
    @(negedge clk);
    m_in_value = 16'hA5C3; m_in_valid = 1'b1; m_repeat_en = 1'b1;
    push_lead();
    push_frame(16'hA5C3, 16, 1'b1); push_gap(1'b1);
    push_frame(16'hA5C3, 16, 1'b1); push_gap(1'b1);
    push_frame(16'hA5C3, 16, 1'b1); push_gap(1'b0);
    push_idle(3);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({m_leds, m_digit_idx, m_frame_done, m_busy} !== e) begin
        errors++;
        $display("FAIL repeat_trace c=%0d got %h exp %h", c, {m_leds, m_digit_idx, m_frame_done, m_busy}, e);
      end
      fd_cnt += int'(m_frame_done);
      if (c == 1) m_in_valid = 1'b0;
      if (c == 42) m_repeat_en = 1'b0;
    end
    checks++;
    if (fd_cnt != 3) begin
      errors++;
      $display("FAIL repeat_frame_done_count got %0d exp 3", fd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int         n;
    int         fd_cnt = 0;
    int         ffff_c = -1;
    logic [7:0] e;
    exp_q.delete();
    @(negedge clk);
    m_in_value = 16'hA5C3; m_in_valid = 1'b1; m_repeat_en = 1'b0;
    push_lead();
    push_frame(16'hA5C3, 16, 1'b1); push_gap(1'b1);
    push_frame(16'h1234, 16, 1'b1); push_gap(1'b1);
    push_frame(16'hFFFF, 16, 1'b1); push_gap(1'b0);
    push_idle(3);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({m_leds, m_digit_idx, m_frame_done, m_busy} !== e) begin
        errors++;
        $display("FAIL b2b_trace c=%0d got %h exp %h", c, {m_leds, m_digit_idx, m_frame_done, m_busy}, e);
      end
      fd_cnt += int'(m_frame_done);
      if (c == 1) begin
        m_in_valid = 1'b0;
      end else if (c == 8) begin
        checks++;
        if (m_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_digit1 got %b exp 1", m_in_ready);
        end
        m_in_value = 16'h1234; m_in_valid = 1'b1;
      end else if (c == 9) begin
        checks++;
        if (m_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_hold_off got %b exp 0", m_in_ready);
        end
        m_in_value = 16'hFFFF;
      end else if (c > 9 && m_in_valid) begin
        if (ffff_c >= 0) m_in_valid = 1'b0;
        else if (m_in_ready) ffff_c = c;
      end
    end
    checks++;
    if (ffff_c != 20) begin
      errors++;
      $display("FAIL b2b_second_accept_cycle got %0d exp 20", ffff_c);
    end
    checks++;
    if (fd_cnt != 3) begin
      errors++;
      $display("FAIL b2b_frame_done_count got %0d exp 3", fd_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int         n;
    logic [7:0] e;
    exp_q.delete();
    @(negedge clk);
    m_in_value = 16'hA5C3; m_in_valid = 1'b1; m_repeat_en = 1'b1;
    push_lead(); push_frame(16'hA5C3, 10, 1'b1); push_idle(20);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({m_leds, m_digit_idx, m_frame_done, m_busy} !== e) begin
        errors++;
        $display("FAIL rstmid_trace c=%0d got %h exp %h", c, {m_leds, m_digit_idx, m_frame_done, m_busy}, e);
      end
      if (c == 1) m_in_valid = 1'b0;
      if (c == 5) begin
        m_in_value = 16'h1234; m_in_valid = 1'b1;
      end
      if (c == 6) begin
        checks++;
        if (m_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_pending_full got ready=%b exp 0", m_in_ready);
        end
        m_in_valid = 1'b0;
      end
      if (c == 12) m_rst = 1'b1;
      if (c == 13) begin
        checks++;
        if (m_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_ready_after got %b exp 1", m_in_ready);
        end
        m_rst = 1'b0;
      end
    end
    m_repeat_en = 1'b0;
  endtask

  task automatic test_gap_zero();
    int         n;
    int         fd_cnt = 0;
    logic [7:0] e;
    exp_q.delete();
    @(negedge clk);
    g_in_value = 16'hA5C3; g_in_valid = 1'b1; g_repeat_en = 1'b1;
    push_lead();
    push_frame(16'hA5C3, 16, 1'b1);
    push_frame(16'hA5C3, 16, 1'b1);
    push_frame(16'hA5C3, 16, 1'b0);
    push_idle(3);
    n = exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({g_leds, g_digit_idx, g_frame_done, g_busy} !== e) begin
        errors++;
        $display("FAIL gap0_trace c=%0d got %h exp %h", c, {g_leds, g_digit_idx, g_frame_done, g_busy}, e);
      end
      fd_cnt += int'(g_frame_done);
      if (c == 1) g_in_valid = 1'b0;
      if (c == 38) g_repeat_en = 1'b0;
    end
    checks++;
    if (fd_cnt != 3) begin
      errors++;
      $display("FAIL gap0_frame_done_count got %0d exp 3", fd_cnt);
    end
  endtask

  task automatic test_pwm();
    int hi = 0;
    int exp_d;
    duty_q.delete();
    @(negedge clk);
    p_in_value = 16'h1234; p_in_valid = 1'b1; p_repeat_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int v;
      v = 256 >> (2 * k);
      if (v > 255) v = 255;
      if (k == 3) v = 0;
      duty_q.push_back(v);
    end
    for (int c = 1; c <= 3 + 4096 + 4; c++) begin
      @(negedge clk);
      if (c == 1) p_in_valid = 1'b0;
      if (c >= 3 && c < 3 + 4096) begin
        int k;
        int off;
        k   = (c - 3) / 1024;
        off = (c - 3) % 1024;
        if (off >= 512 && off < 768) hi += int'(p_led_pos);
        if (off == 768) begin
          exp_d = duty_q.pop_front();
          checks++;
          if (hi != exp_d) begin
            errors++;
            $display("FAIL pwm_duty digit=%0d got %0d exp %0d", k, hi, exp_d);
          end
          checks++;
          if (p_digit_idx !== 2'(k)) begin
            errors++;
            $display("FAIL pwm_digit_idx got %0d exp %0d", p_digit_idx, k);
          end
          hi = 0;
        end
      end
    end
    checks++;
    if (p_busy !== 1'b0) begin
      errors++;
      $display("FAIL pwm_idle_after got busy=%b exp 0", p_busy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    m_rst = 1'b1; m_in_value = '0; m_in_valid = 1'b0; m_repeat_en = 1'b0;
    p_rst = 1'b1; p_in_value = '0; p_in_valid = 1'b0; p_repeat_en = 1'b0;
    g_rst = 1'b1; g_in_value = '0; g_in_valid = 1'b0; g_repeat_en = 1'b0;
    test_reset();
    test_single_frame();
    test_repeat();
    test_back_to_back();
    test_reset_mid();
    test_gap_zero();
    test_pwm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
